// File: rtl/pipeline_stage_skid.sv
// pipeline_stage_skid
//   Registered pipeline stage carrying a DATA_W-bit payload. The stage holds a
//   head entry, which drives out_*. With PIPELINE_STAGE_SKID_EN defined it also
//   holds one skid entry, so in_ready comes straight from a flop. Without the
//   macro there is no skid entry, and in_ready is combinational.
//   An empty entry always carries an all-zero payload.
//   While the head is stalled, patch_en overwrites the head's in-place fields:
//   the request field [REQ_LSB +: REQ_W] is cleared and the patch field
//   [PATCH_LSB +: PATCH_W] is loaded with patch_data.
//
// Ports
//   CLK, RST            clock; synchronous active-high reset
//   in_valid/in_ready   upstream handshake, in_data payload
//   out_valid/out_ready downstream handshake, out_data registered head payload
//   flush               drops every held entry and any same-cycle input
//   patch_en/patch_data memory response for the stalled head
//   occupancy           registered count of held entries
//
// Build option: PIPELINE_STAGE_SKID_EN enables the skid entry.
module pipeline_stage_skid #(
  parameter int unsigned DATA_W    = 160,
  parameter int unsigned REQ_LSB   = 0,
  parameter int unsigned REQ_W     = 2,
  parameter int unsigned PATCH_LSB = 2,
  parameter int unsigned PATCH_W   = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  input  logic               flush,
  input  logic               patch_en,
  input  logic [PATCH_W-1:0] patch_data,
  output logic [1:0]         occupancy
);

  if (REQ_W == 0 || PATCH_W == 0 ||
      REQ_LSB + REQ_W > DATA_W || PATCH_LSB + PATCH_W > DATA_W) begin : g_bad_range
    $error("pipeline_stage_skid: REQ/PATCH field exceeds DATA_W or has zero width");
  end
  if (!((REQ_LSB + REQ_W <= PATCH_LSB) || (PATCH_LSB + PATCH_W <= REQ_LSB))) begin : g_overlap
    $error("pipeline_stage_skid: REQ and PATCH fields overlap");
  end

  logic              head_valid_q, head_valid_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [1:0]        occ_q, occ_d;
  logic              in_fire;
  logic              out_fire;
  logic              patch_hit;

  assign out_fire  = head_valid_q & out_ready;
  assign patch_hit = patch_en & head_valid_q & ~out_ready;

  assign out_valid = head_valid_q;
  assign out_data  = head_q;
  assign occupancy = occ_q;

`ifdef PIPELINE_STAGE_SKID_EN
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;

  assign in_ready = in_ready_q;
  assign in_fire  = in_valid & in_ready_q;

  always_comb begin
    head_valid_d = head_valid_q;
    head_d       = head_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (out_fire) begin
      if (skid_valid_q) begin
        head_d       = skid_q;
        skid_valid_d = in_fire;
        skid_d       = in_data;
      end else if (in_fire) begin
        head_d = in_data;
      end else begin
        head_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      if (!head_valid_q) begin
        head_valid_d = 1'b1;
        head_d       = in_data;
      end else begin
        skid_valid_d = 1'b1;
        skid_d       = in_data;
      end
    end
    // A patch only happens without an out fire, so head_d still holds head_q.
    if (patch_hit) begin
      head_d[REQ_LSB +: REQ_W]     = '0;
      head_d[PATCH_LSB +: PATCH_W] = patch_data;
    end
    if (flush) begin
      head_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end
    if (!head_valid_d) head_d = '0;
    if (!skid_valid_d) skid_d = '0;
    in_ready_d = ~skid_valid_d;
    occ_d      = {1'b0, head_valid_d} + {1'b0, skid_valid_d};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      head_valid_q <= 1'b0;
      head_q       <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      in_ready_q   <= 1'b0;
      occ_q        <= '0;
    end else begin
      head_valid_q <= head_valid_d;
      head_q       <= head_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
      in_ready_q   <= in_ready_d;
      occ_q        <= occ_d;
    end
  end
`else
  // ready_en_q keeps in_ready low during reset and for one cycle after it,
  // which matches the timing of the registered-ready build.
  logic ready_en_q, ready_en_d;

  assign ready_en_d = 1'b1;
  assign in_ready   = ready_en_q & (~head_valid_q | out_ready);
  assign in_fire    = in_valid & in_ready;

  always_comb begin
    head_valid_d = head_valid_q;
    head_d       = head_q;
    if (out_fire) begin
      if (in_fire) head_d = in_data;
      else         head_valid_d = 1'b0;
    end else if (in_fire) begin
      head_valid_d = 1'b1;
      head_d       = in_data;
    end
    if (patch_hit) begin
      head_d[REQ_LSB +: REQ_W]     = '0;
      head_d[PATCH_LSB +: PATCH_W] = patch_data;
    end
    if (flush) head_valid_d = 1'b0;
    if (!head_valid_d) head_d = '0;
    occ_d = {1'b0, head_valid_d};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      head_valid_q <= 1'b0;
      head_q       <= '0;
      ready_en_q   <= 1'b0;
      occ_q        <= '0;
    end else begin
      head_valid_q <= head_valid_d;
      head_q       <= head_d;
      ready_en_q   <= ready_en_d;
      occ_q        <= occ_d;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_stage_skid.sv
// Testbench for pipeline_stage_skid.
// It runs a per-cycle vector table, then hand-written corner sequences, then a
// random stream that is checked against a scoreboard queue.
// It adapts its expectations to PIPELINE_STAGE_SKID_EN.
module tb_pipeline_stage_skid;
  localparam int unsigned DW = 160;
`ifdef PIPELINE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST, in_valid, in_ready, out_valid, out_ready, flush, patch_en;
  logic [DW-1:0] in_data, out_data;
  logic [31:0]   patch_data;
  logic [1:0]    occupancy;

  always #5 CLK = ~CLK;

  pipeline_stage_skid #(
    .DATA_W(DW), .REQ_LSB(0), .REQ_W(2), .PATCH_LSB(2), .PATCH_W(32)
  ) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .patch_en(patch_en), .patch_data(patch_data),
    .occupancy(occupancy)
  );

  typedef struct {
    logic          rst, fl, iv;
    logic [DW-1:0] id;
    logic          ordy, pen;
    logic [31:0]   pd;
    logic          e_ov;
    logic [DW-1:0] e_od;
    logic [1:0]    e_occ;
    logic          e_ir;
  } vec_t;

  vec_t          vt[11];
  int            n_cmp = 0;
  int            n_fail = 0;
  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] d1, d2, d3, exp_d;

  function automatic vec_t mk(logic rst, logic fl, logic iv, logic [DW-1:0] id,
                              logic ordy, logic pen, logic [31:0] pd,
                              logic e_ov, logic [DW-1:0] e_od, logic [1:0] e_occ,
                              logic e_ir);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy; v.pen = pen;
    v.pd = pd; v.e_ov = e_ov; v.e_od = e_od; v.e_occ = e_occ; v.e_ir = e_ir;
    return v;
  endfunction

  function automatic logic [DW-1:0] patched(logic [DW-1:0] d, logic [31:0] p);
    logic [DW-1:0] r;
    r       = d;
    r[1:0]  = 2'b00;
    r[33:2] = p;
    return r;
  endfunction

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic ov, input logic [DW-1:0] od,
                            input logic [1:0] occ, input logic ir);
    check({tag, " out_valid"}, DW'(out_valid), DW'(ov));
    check({tag, " out_data"},  out_data, od);
    check({tag, " occupancy"}, DW'(occupancy), DW'(occ));
    check({tag, " in_ready"},  DW'(in_ready), DW'(ir));
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic rst, input logic fl, input logic iv,
                       input logic [DW-1:0] id, input logic ordy, input logic pen,
                       input logic [31:0] pd);
    RST = rst; flush = fl; in_valid = iv; in_data = id;
    out_ready = ordy; patch_en = pen; patch_data = pd;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    d1 = 160'hF00D_0000_0001_2345_6789;
    d2 = 160'h1234_5678_9ABC_DEF0_0000_0003;
    d3 = 160'h3333;
    //       rst fl iv id      ordy pen pd              ov od              occ ir
    vt[0]  = mk(1, 0, 1, 'h77,  1,  0, 0,            0, 0,              0, 0);
    vt[1]  = mk(1, 0, 0, 0,     1,  0, 0,            0, 0,              0, 0);
    vt[2]  = mk(0, 0, 1, 'h11,  1,  0, 0,            0, 0,              0, 1);
    vt[3]  = mk(0, 0, 1, 'hA5,  1,  0, 0,            1, 'hA5,           1, 1);
    vt[4]  = mk(0, 0, 0, 0,     1,  0, 0,            0, 0,              0, 1);
    vt[5]  = mk(0, 0, 0, 0,     0,  1, 32'hFFFFFFFF, 0, 0,              0, 1);
    vt[6]  = mk(0, 0, 1, d1,    0,  0, 0,            1, d1,             1, SKID);
    vt[7]  = mk(0, 0, 0, 0,     0,  1, 32'hDEADBEEF, 1, patched(d1, 32'hDEADBEEF), 1, SKID);
    vt[8]  = mk(0, 0, 1, d2,    1,  1, 32'h12345678, 1, d2,             1, 1);
    vt[9]  = mk(0, 1, 1, d3,    0,  1, 0,            0, 0,              0, 1);
    vt[10] = mk(0, 0, 0, 0,     1,  0, 0,            0, 0,              0, 1);

    for (int i = 0; i < 11; i++) begin
      drive(vt[i].rst, vt[i].fl, vt[i].iv, vt[i].id, vt[i].ordy, vt[i].pen, vt[i].pd);
      tick();
      check_outs($sformatf("vec%0d", i), vt[i].e_ov, vt[i].e_od, vt[i].e_occ, vt[i].e_ir);
    end

    // Back-pressure: push A then B while stalled, then release.
    drive(0, 0, 1, 160'hA, 0, 0, 0); tick();
    check_outs("bp pushA", 1, 160'hA, 1, SKID);
    drive(0, 0, 1, 160'hB, 0, 0, 0); tick();
    check_outs("bp pushB", 1, 160'hA, SKID ? 2'd2 : 2'd1, 0);
    drive(0, 0, 0, 0, 1, 0, 0); tick();
    if (SKID) check_outs("bp relA", 1, 160'hB, 1, 1);
    else      check_outs("bp relA", 0, 0, 0, 1);
    tick();
    check_outs("bp relB", 0, 0, 0, 1);

    // Flush with a full stage and a same-cycle input.
    drive(0, 0, 1, 160'hA, 0, 0, 0); tick();
    drive(0, 0, 1, 160'hB, 0, 0, 0); tick();
    drive(0, 1, 1, 160'hC, 0, 1, 32'h1); tick();
    check_outs("flush", 0, 0, 0, 1);

    // Reset mid-stream, then a normal push.
    drive(0, 0, 1, 160'hA, 0, 0, 0); tick();
    drive(0, 0, 1, 160'hB, 0, 0, 0); tick();
    drive(1, 0, 1, 160'hD, 0, 1, 32'h5); tick();
    check_outs("rst hold", 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    check_outs("rst rel", 0, 0, 0, 1);
    drive(0, 0, 1, 160'hE, 1, 0, 0); tick();
    check_outs("rst push", 1, 160'hE, 1, 1);
    drive(0, 0, 0, 0, 1, 0, 0); tick();
    check_outs("rst drain", 0, 0, 0, 1);

    // Random stream against the scoreboard.
    for (int c = 0; c < 10000; c++) begin
      logic [DW-1:0] rd;
      rd          = '0;
      rd[31:0]    = c;
      rd[63:32]   = $urandom;
      rd[159:128] = $urandom;
      drive(0, 0, 1'($urandom_range(0, 1)), rd, 1'($urandom_range(0, 1)), 0, 0);
      @(negedge CLK);
      check("rand occupancy", DW'(occupancy), DW'(sb_q.size()));
      check("rand in_ready", DW'(in_ready),
            DW'(SKID ? (sb_q.size() < 2) : (sb_q.size() == 0 || out_ready)));
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL rand pop: got %0h expected nothing (queue empty)", out_data);
        end else begin
          exp_d = sb_q.pop_front();
          check("rand out_data", out_data, exp_d);
        end
      end
      if (in_valid && in_ready) sb_q.push_back(in_data);
      tick();
    end

    // Drain the stage with a bounded number of cycles.
    drive(0, 0, 0, 0, 1, 0, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL drain pop: got %0h expected nothing (queue empty)", out_data);
        end else begin
          exp_d = sb_q.pop_front();
          check("drain out_data", out_data, exp_d);
        end
      end
      tick();
    end
    check("drain leftover", DW'(sb_q.size()), 0);
    check("drain out_valid", DW'(out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_stage_skid.md
PIPELINE_STAGE_SKID -- requirements
Module: pipeline_stage_skid

Interface
REQ-001 SHALL have parameter DATA_W, default 160, total payload width in bits.
REQ-002 SHALL have parameter REQ_LSB, default 0, LSB of the memory-request field inside the payload.
REQ-003 SHALL have parameter REQ_W, default 2, width of the request field (e.g. dREN/dWEN).
REQ-004 SHALL have parameter PATCH_LSB, default 2, LSB of the patchable data field inside the payload.
REQ-005 SHALL have parameter PATCH_W, default 32, width of the patchable data field.
REQ-006 SHALL have port CLK, input, 1, sole clock; all state updates on rising edge.
REQ-007 SHALL have port RST, input, 1; reset is synchronous and active-high.
REQ-008 SHALL have port in_valid, input, 1, upstream entry present.
REQ-009 SHALL have port in_ready, output, 1, stage accepts an entry this cycle.
REQ-010 SHALL have port in_data, input, DATA_W, upstream payload.
REQ-011 SHALL have port out_valid, output, 1, head entry present.
REQ-012 SHALL have port out_ready, input, 1, downstream consumes the head.
REQ-013 SHALL have port out_data, output, DATA_W, head payload (registered).
REQ-014 SHALL have port flush, input, 1, discard all held entries.
REQ-015 SHALL have port patch_en, input, 1, memory response for the stalled head.
REQ-016 SHALL have port patch_data, input, PATCH_W, memory response data.
REQ-017 SHALL have port occupancy, output, 2, held entry count, 0..2.

Function
REQ-018 SHALL hold a head register (drives out_*) and one skid register; in fire = in_valid&in_ready; out fire = out_valid&out_ready.
REQ-019 SHALL drive in_ready = !skid_valid, registered, with no combinational path from out_ready.
REQ-020 SHALL deliver entries in strict arrival order; latency from in fire into an empty stage to out_valid is 1 cycle.
REQ-021 On out fire: head <= skid if skid valid, else in_data if in fire, else empty.
REQ-022 With no out fire: an in fire fills the head if empty, otherwise the skid.
REQ-023 SHALL force out_data and the skid payload to all-zero whenever the corresponding valid is 0 (bubble).
REQ-024 flush SHALL empty both entries and zero the payloads next cycle, dropping any same-cycle input; flush overrides handshakes and patch.
REQ-025 patch_en with out_valid=1 and out_ready=0 SHALL zero the head's REQ field and load patch_data into its PATCH field; other bits and the skid are unchanged.
REQ-026 patch_en SHALL be ignored when the head is empty or fires that cycle.
REQ-027 occupancy SHALL equal head_valid + skid_valid, registered.
REQ-028 Overlapping REQ/PATCH fields or fields exceeding DATA_W SHALL be flagged by an elaboration-time error.

Reset
REQ-029 While RST=1: out_valid=0, skid empty, out_data=0, occupancy=0, in_ready=0; in_ready=1 on the first cycle after RST falls.
REQ-030 RST SHALL override flush, patch and handshakes; an entry accepted in the cycle RST rises SHALL be lost.

Configuration
REQ-031 With PIPELINE_STAGE_SKID_EN defined: the two-entry behaviour above.
REQ-032 Without PIPELINE_STAGE_SKID_EN: no skid register; in_ready = !out_valid | out_ready (combinational); occupancy max 1; all other rules unchanged.

Verification
REQ-033 Empty stage, in_data=0xA5 held valid 1 cycle, out_ready=1 -> out_valid=1 with out_data=0xA5 next cycle, then 0 and data 0.
REQ-034 out_ready=0, push A then B -> occupancy 2, in_ready=0; raise out_ready -> A then B on consecutive cycles, in_ready back to 1.
REQ-035 Head stalled with REQ field=2'b01, patch_en=1, patch_data=0xDEADBEEF -> next cycle REQ=0, PATCH=0xDEADBEEF, head still valid.
REQ-036 occupancy 2 plus in_valid and flush same cycle -> occupancy 0, out_valid=0, out_data=0, in_ready=1 next cycle.
REQ-037 RST asserted mid-stream with occupancy 2 -> all outputs zero and in_ready=0 next cycle; the first post-reset push emerges normally.
REQ-038 Random in_valid/out_ready at 50% over 10000 cycles -> output sequence equals input sequence, no loss or duplication, both with and without the macro.
